// File: rtl/smb_stream_ctrl_if.sv
// Handshake bundle shared by the feature-map source, the SMB window buffer and the systolic-array stall.
// master: the stream controller side; slave: the surrounding datapath.
interface smb_stream_ctrl_if #(
  parameter int M = 8
);
  logic [M-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [M-1:0] win_din;
  logic         win_valid;
  logic         win_repeat;
  logic         win_finish;
  logic         sa_stall;

  modport master (
    input  s_data, s_valid, win_finish, sa_stall,
    output s_ready, win_din, win_valid, win_repeat
  );

  modport slave (
    output s_data, s_valid, win_finish, sa_stall,
    input  s_ready, win_din, win_valid, win_repeat
  );
endinterface

// File: rtl/smb_stream_ctrl.sv
// Streams one zero-padded (H+2)x(W+2) frame into the SMB window buffer, flushes it, then waits for fmap_finish.
// Optional stall performance counter is built only when SMB_CTRL_PERF_EN is defined.
module smb_stream_ctrl #(
  parameter int M         = 8,
  parameter int W_MAX     = 480,
  parameter int H_MAX     = 256,
  parameter int DRAIN_MAX = 64
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [8:0]        cfg_width,
  input  logic [8:0]        cfg_height,
  smb_stream_ctrl_if.master bus,
  output logic [8:0]        row_idx,
  output logic [8:0]        col_idx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       stall_cnt
);

  localparam logic [8:0]      W_MAX_V    = 9'(W_MAX);
  localparam logic [8:0]      H_MAX_V    = 9'(H_MAX);
  localparam int              DC_W       = $clog2(DRAIN_MAX + 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_MAX - 1);
  localparam logic [DC_W-1:0] DRAIN_ONE  = DC_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAD_TOP = 3'd1,
    ST_ROW     = 3'd2,
    ST_PAD_BOT = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t          state_r;
  logic [8:0]      w_last_r;
  logic [8:0]      h_r;
  logic [8:0]      row_r;
  logic [8:0]      col_r;
  logic [DC_W-1:0] drain_cnt_r;
  logic            win_valid_r;
  logic [M-1:0]    win_din_r;
  logic            busy_r;
  logic            done_r;
  logic            err_r;

  logic in_row_s;
  logic in_frame_s;
  logic last_col_s;
  logic pad_col_s;
  logic pixel_col_s;
  logic s_ready_s;
  logic win_repeat_s;
  logic cfg_ok_s;
  logic beat_s;

  // Position decode, beat qualification and config range check
  always_comb begin
    in_row_s     = (state_r == ST_ROW);
    in_frame_s   = (state_r == ST_PAD_TOP) || (state_r == ST_ROW) || (state_r == ST_PAD_BOT);
    last_col_s   = (col_r == w_last_r);
    pad_col_s    = (col_r == 9'd0) || last_col_s;
    pixel_col_s  = in_row_s && !pad_col_s;
    s_ready_s    = pixel_col_s && !bus.sa_stall;
    win_repeat_s = (state_r == ST_DRAIN) && !bus.sa_stall;
    cfg_ok_s     = (cfg_width != 9'd0) && (cfg_width <= W_MAX_V) &&
                   (cfg_height != 9'd0) && (cfg_height <= H_MAX_V);
    if (!in_frame_s || bus.sa_stall) begin
      beat_s = 1'b0;
    end else if (pixel_col_s) begin
      beat_s = bus.s_valid;
    end else begin
      beat_s = 1'b1;
    end
  end

  // Frame sequencer: walks padded rows/columns, drains the window pipe and reports completion
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_r     <= ST_IDLE;
      w_last_r    <= 9'd0;
      h_r         <= 9'd0;
      row_r       <= 9'd0;
      col_r       <= 9'd0;
      drain_cnt_r <= '0;
      win_valid_r <= 1'b0;
      win_din_r   <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      win_valid_r <= beat_s;
      win_din_r   <= (beat_s && pixel_col_s) ? bus.s_data : '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && cfg_ok_s) begin
            w_last_r    <= cfg_width + 9'd1;
            h_r         <= cfg_height;
            row_r       <= 9'd0;
            col_r       <= 9'd0;
            drain_cnt_r <= '0;
            busy_r      <= 1'b1;
            state_r     <= ST_PAD_TOP;
          end else if (start) begin
            err_r <= 1'b1;
          end
        end
        ST_PAD_TOP: begin
          if (beat_s && last_col_s) begin
            col_r   <= 9'd0;
            row_r   <= row_r + 9'd1;
            state_r <= ST_ROW;
          end else if (beat_s) begin
            col_r <= col_r + 9'd1;
          end
        end
        ST_ROW: begin
          if (beat_s && last_col_s) begin
            col_r <= 9'd0;
            row_r <= row_r + 9'd1;
            if (row_r == h_r) begin
              state_r <= ST_PAD_BOT;
            end
          end else if (beat_s) begin
            col_r <= col_r + 9'd1;
          end
        end
        ST_PAD_BOT: begin
          // Row index parks on H+1 while draining; only the column wraps
          if (beat_s && last_col_s) begin
            col_r       <= 9'd0;
            drain_cnt_r <= '0;
            state_r     <= ST_DRAIN;
          end else if (beat_s) begin
            col_r <= col_r + 9'd1;
          end
        end
        ST_DRAIN: begin
          if (!bus.sa_stall) begin
            if (bus.win_finish) begin
              done_r  <= 1'b1;
              row_r   <= 9'd0;
              col_r   <= 9'd0;
              state_r <= ST_DONE;
            end else if (drain_cnt_r == DRAIN_LAST) begin
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              row_r   <= 9'd0;
              col_r   <= 9'd0;
              state_r <= ST_DONE;
            end else begin
              drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
            end
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          row_r   <= 9'd0;
          col_r   <= 9'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready    = s_ready_s;
  assign bus.win_repeat = win_repeat_s;
  assign bus.win_valid  = win_valid_r;
  assign bus.win_din    = win_din_r;
  assign row_idx        = row_r;
  assign col_idx        = col_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;

`ifdef SMB_CTRL_PERF_EN
  logic [31:0] stall_cnt_r;
  logic        stall_evt_s;
  logic        start_acc_s;

  // Stall event: array backpressure, or a pixel column starved by the source
  always_comb begin
    stall_evt_s = busy_r && (bus.sa_stall || (pixel_col_s && !bus.s_valid));
    start_acc_s = (state_r == ST_IDLE) && start && cfg_ok_s;
  end

  // Saturating stall counter, cleared when a new frame is accepted
  always_ff @(posedge clk) begin
    if (Rst) begin
      stall_cnt_r <= 32'd0;
    end else if (start_acc_s) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_evt_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
